// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg: RAM geometry shared by the RAM and its burst master, plus the
// burst-master state encoding.
package mem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_burst_master_if.sv
`default_nettype none
// ram_burst_master_if: command, write-data, read-data and RAM-side signals of
// the burst master. The master modport is the burst master's own view.
interface ram_burst_master_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int LEN_W  = ADDR_W + 1
);

  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_write;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [LEN_W-1:0]  i_cmd_len;

  logic              i_wdata_valid;
  logic              o_wdata_ready;
  logic [DATA_W-1:0] i_wdata;

  logic              o_rdata_valid;
  logic              i_rdata_ready;
  logic [DATA_W-1:0] o_rdata;
  logic              o_rdata_last;

  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_data;
  logic [DATA_W-1:0] i_ram_data;

  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
    input  i_wdata_valid, i_wdata, i_rdata_ready, i_ram_data,
    output o_cmd_ready, o_wdata_ready, o_rdata_valid, o_rdata, o_rdata_last,
    output o_ram_we, o_ram_addr, o_ram_data, o_busy, o_done
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
    output i_wdata_valid, i_wdata, i_rdata_ready, i_ram_data,
    input  o_cmd_ready, o_wdata_ready, o_rdata_valid, o_rdata, o_rdata_last,
    input  o_ram_we, o_ram_addr, o_ram_data, o_busy, o_done
  );

endinterface
`default_nettype wire

// File: rtl/ram_burst_master.sv
`default_nettype none
// ram_burst_master: turns burst commands into sequential accesses on a
// single-port RAM with combinational read; read words leave via a skid-free register.
module ram_burst_master #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ram_burst_master_if.master bus
);

  mem_pkg::state_t   state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  issue_rem;
  logic              rd_primed;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              rdata_last;

  logic              cmd_ready, wdata_ready, ram_we, busy, done;
  logic [DATA_W-1:0] ram_data;
  logic              load, consume, beat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= mem_pkg::IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    ram_we      = 1'b0;
    ram_data    = '0;
    busy        = 1'b1;
    done        = 1'b0;
    load        = 1'b0;
    beat        = 1'b0;
    consume     = rdata_valid && bus.i_rdata_ready;
    case (state)
      mem_pkg::IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (bus.i_cmd_valid) begin
          if (bus.i_cmd_len == '0) state_nxt = mem_pkg::DONE;
          else if (bus.i_cmd_write) state_nxt = mem_pkg::WRITE;
          else state_nxt = mem_pkg::READ;
        end
      end
      mem_pkg::WRITE: begin
        wdata_ready = 1'b1;
        ram_we      = bus.i_wdata_valid;
        ram_data    = bus.i_wdata;
        beat        = bus.i_wdata_valid;
        if (beat && issue_rem == LEN_W'(1)) state_nxt = mem_pkg::DONE;
      end
      mem_pkg::READ: begin
        // First READ cycle only primes; loading starts one cycle after acceptance.
        load = rd_primed && (issue_rem != '0) && (!rdata_valid || bus.i_rdata_ready);
        if (consume && rdata_last) state_nxt = mem_pkg::DONE;
      end
      mem_pkg::DONE: begin
        done      = 1'b1;
        state_nxt = mem_pkg::IDLE;
      end
      default: state_nxt = mem_pkg::IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_addr    <= '0;
      issue_rem   <= '0;
      rd_primed   <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
    end else begin
      case (state)
        mem_pkg::IDLE: begin
          rd_primed <= 1'b0;
          if (bus.i_cmd_valid) begin
            cur_addr  <= bus.i_cmd_addr;
            issue_rem <= bus.i_cmd_len;
          end
        end
        mem_pkg::WRITE: begin
          if (beat) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            issue_rem <= issue_rem - LEN_W'(1);
          end
        end
        mem_pkg::READ: begin
          rd_primed <= 1'b1;
          if (load) begin
            rdata       <= bus.i_ram_data;
            rdata_valid <= 1'b1;
            rdata_last  <= (issue_rem == LEN_W'(1));
            cur_addr    <= cur_addr + ADDR_W'(1);
            issue_rem   <= issue_rem - LEN_W'(1);
          end else if (consume) begin
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_wdata_ready = wdata_ready;
  assign bus.o_rdata_valid = rdata_valid;
  assign bus.o_rdata       = rdata;
  assign bus.o_rdata_last  = rdata_last;
  assign bus.o_ram_we      = ram_we;
  assign bus.o_ram_addr    = cur_addr;
  assign bus.o_ram_data    = ram_data;
  assign bus.o_busy        = busy;
  assign bus.o_done        = done;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_master.sv
`default_nettype none
// tb_ram_burst_master: directed and randomized bursts against a word-array
// model of the RAM contents and the burst timing rules.
module tb_ram_burst_master;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int LW    = 6;
  localparam int DEPTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram_burst_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  ram_burst_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_data;
  assign bus.i_ram_data = ram[bus.o_ram_addr];

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wbuf  [DEPTH];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit wr, input int addr, input int len);
    int b = 0;
    while (!bus.o_cmd_ready && b < 50) begin tick(); b++; end
    chk("cmd_ready_wait", bus.o_cmd_ready, 1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = wr;
    bus.i_cmd_addr  = AW'(addr);
    bus.i_cmd_len   = LW'(len);
    tick();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_write = 1'($urandom);
    bus.i_cmd_addr  = AW'($urandom);
    bus.i_cmd_len   = LW'($urandom_range(0, 32));
  endtask

  // Called just after the edge that completes a burst.
  task automatic finish_done();
    chk("done_pulse", bus.o_done, 1);
    chk("done_cmd_ready", bus.o_cmd_ready, 0);
    chk("done_busy", bus.o_busy, 1);
    tick();
    chk("done_clear", bus.o_done, 0);
    chk("idle_cmd_ready", bus.o_cmd_ready, 1);
    chk("idle_busy", bus.o_busy, 0);
  endtask

  task automatic zero_len_tail();
    chk("zl_we", bus.o_ram_we, 0);
    chk("zl_rvalid", bus.o_rdata_valid, 0);
    finish_done();
  endtask

  task automatic write_burst(input int addr, input int len, input bit gaps);
    int a = addr;
    bus.i_wdata_valid = 1'b0;
    issue(1'b1, addr, len);
    if (len == 0) begin zero_len_tail(); return; end
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.i_wdata_valid = 1'b0;
          bus.i_wdata       = $urandom;
          bus.i_cmd_valid   = 1'($urandom);
          #1;
          chk("gap_we", bus.o_ram_we, 0);
          chk("wr_cmd_ready", bus.o_cmd_ready, 0);
          tick();
        end
      end
      bus.i_wdata_valid = 1'b1;
      bus.i_wdata       = wbuf[i];
      bus.i_cmd_valid   = (i == len - 1) ? 1'b0 : 1'($urandom);
      #1;
      chk("wr_ready", bus.o_wdata_ready, 1);
      chk("wr_addr", bus.o_ram_addr, a);
      chk("wr_we", bus.o_ram_we, 1);
      tick();
      model[a] = wbuf[i];
      a = (a + 1) % DEPTH;
    end
    bus.i_wdata_valid = 1'b0;
    bus.i_cmd_valid   = 1'b0;
    finish_done();
  endtask

  task automatic read_burst(input int addr, input int len, input int hold, input bit rnd);
    logic [DW-1:0] expq[$];
    int idx = 0;
    int since = 0;
    bit rdy;
    for (int i = 0; i < len; i++) expq.push_back(model[(addr + i) % DEPTH]);
    bus.i_rdata_ready = 1'b0;
    issue(1'b0, addr, len);
    if (len == 0) begin zero_len_tail(); return; end
    bus.i_wdata_valid = 1'($urandom);
    chk("rd_lat_n", bus.o_rdata_valid, 0);
    tick();
    chk("rd_lat_n1", bus.o_rdata_valid, 0);
    tick();
    chk("rd_first_valid", bus.o_rdata_valid, 1);
    while (idx < len && since < 300) begin
      chk("rd_valid", bus.o_rdata_valid, 1);
      chk("rd_data", bus.o_rdata, expq[idx]);
      chk("rd_last", bus.o_rdata_last, (idx == len - 1));
      chk("rd_we", bus.o_ram_we, 0);
      chk("rd_wready", bus.o_wdata_ready, 0);
      rdy = (since < hold) ? 1'b0 : (rnd ? 1'($urandom) : 1'b1);
      bus.i_rdata_ready = rdy;
      bus.i_wdata_valid = 1'($urandom);
      bus.i_cmd_valid   = (idx == len - 1 && rdy) ? 1'b0 : 1'($urandom);
      tick();
      since++;
      if (rdy) idx++;
    end
    chk("rd_count", idx, len);
    bus.i_rdata_ready = 1'b0;
    bus.i_wdata_valid = 1'b0;
    bus.i_cmd_valid   = 1'b0;
    chk("rd_valid_clear", bus.o_rdata_valid, 0);
    finish_done();
  endtask

  task automatic check_mem();
    for (int i = 0; i < DEPTH; i++) chk($sformatf("mem[%0d]", i), ram[i], model[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, l;
    bus.i_cmd_valid = 0; bus.i_cmd_write = 0; bus.i_cmd_addr = '0; bus.i_cmd_len = '0;
    bus.i_wdata_valid = 0; bus.i_wdata = '0; bus.i_rdata_ready = 0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", bus.o_cmd_ready, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_we", bus.o_ram_we, 0);
    chk("rst_wready", bus.o_wdata_ready, 0);
    chk("rst_rvalid", bus.o_rdata_valid, 0);
    chk("rst_rlast", bus.o_rdata_last, 0);
    chk("rst_rdata", bus.o_rdata, 0);
    chk("rst_done", bus.o_done, 0);
    rst_n = 1'b1;
    tick();

    // Full-length burst starting mid-array: every word written exactly once.
    for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
    write_burst(5, 32, 1'b1);
    check_mem();

    wbuf[0] = 32'hABBA_DEAD; wbuf[1] = 32'hDEAD_BEEF;
    write_burst(3, 2, 1'b0);
    chk("ram3", ram[3], 32'hABBA_DEAD);
    chk("ram4", ram[4], 32'hDEAD_BEEF);

    wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222; wbuf[2] = 32'h3333_3333;
    write_burst(31, 3, 1'b0);
    chk("ram31", ram[31], 32'h1111_1111);
    chk("ram0", ram[0], 32'h2222_2222);
    chk("ram1", ram[1], 32'h3333_3333);
    read_burst(31, 3, 0, 1'b0);

    read_burst(3, 2, 3, 1'b0);

    write_burst(7, 0, 1'b0);
    read_burst(9, 0, 0, 1'b0);

    // Reset while a read word is waiting for the consumer.
    bus.i_rdata_ready = 1'b0;
    issue(1'b0, 0, 4);
    tick(); tick();
    chk("mr_valid_pre", bus.o_rdata_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", bus.o_rdata_valid, 0);
    chk("mr_we", bus.o_ram_we, 0);
    chk("mr_busy", bus.o_busy, 0);
    chk("mr_done", bus.o_done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_cmd_ready", bus.o_cmd_ready, 1);
    chk("mr_done_after", bus.o_done, 0);

    // Reset after one beat of a 4-beat write: only the first word lands.
    issue(1'b1, 8, 4);
    bus.i_wdata_valid = 1'b1; bus.i_wdata = 32'hCAFE_0008;
    tick();
    model[8] = 32'hCAFE_0008;
    bus.i_wdata = 32'hCAFE_0009;
    #1 rst_n = 1'b0;
    #1;
    chk("mw_we", bus.o_ram_we, 0);
    chk("mw_done", bus.o_done, 0);
    tick();
    chk("mw_done2", bus.o_done, 0);
    rst_n = 1'b1;
    bus.i_wdata_valid = 1'b0;
    tick();
    check_mem();
    wbuf[0] = 32'h0BAD_F00D; wbuf[1] = 32'h1234_5678;
    write_burst(20, 2, 1'b0);
    read_burst(7, 3, 0, 1'b1);

    for (int k = 0; k < 16; k++) begin
      a = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, 32);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
        write_burst(a, l, 1'b1);
      end else begin
        read_burst(a, l, $urandom_range(0, 3), 1'b1);
      end
    end
    check_mem();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
